quick_spi_arbiter: RTL and testbench

- Round-robin scheduler that shares one quick_spi master between NUM_REQ requesters.
- Each requester presents a complete transaction descriptor. The block does the following, in order:
  - grants one requester;
  - writes the master's byte-addressed register map (config bytes 1–11, write buffer from address 12);
  - sets the start bit at address 0;
  - polls until the master clears the start bit;
  - reads back the read buffer from address 30;
  - pulses done to the granted requester.
- Sits between the application requesters and the quick_spi config port.

---
 rtl/quick_spi_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_quick_spi_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quick_spi_arbiter.sv
// Round-robin scheduler sharing one quick_spi master between NUM_REQ
// requesters: loads the master's register map, kicks it, polls for
// completion (with timeout abort), reads back the rx buffer and pulses done.
module quick_spi_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned MAX_TX_BYTES   = 4,
   parameter int unsigned MAX_RX_BYTES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [NUM_REQ-1:0]                req,
   input  logic [NUM_REQ*96-1:0]             req_desc,
   input  logic [NUM_REQ*MAX_TX_BYTES*8-1:0] req_tx_data,
   output logic [NUM_REQ-1:0]                gnt,
   output logic [NUM_REQ-1:0]                done,
   output logic                              err,
   output logic [MAX_RX_BYTES*8-1:0]         rx_data,
   output logic [7:0]                        spi_addr,
   output logic [7:0]                        spi_wdata,
   output logic                              spi_we,
   input  logic [7:0]                        spi_rdata
);

   localparam int unsigned IW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned LOAD_LAST = 10 + MAX_TX_BYTES;

   typedef enum logic [2:0] {
      S_IDLE, S_ARB, S_LOAD, S_KICK, S_POLL, S_READ, S_ABORT, S_DONE
   } state_t;

   state_t                       state_q, state_d;
   logic [IW-1:0]                rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]                win_q, win_d;
   logic [NUM_REQ-1:0]           gnt_q, gnt_d;
   logic [95:0]                  desc_q, desc_d;
   logic [MAX_TX_BYTES*8-1:0]    tx_q, tx_d;
   logic [5:0]                   cnt_q, cnt_d;
   logic [CW-1:0]                poll_cnt_q, poll_cnt_d;
   logic                         phase_q, phase_d;
   logic                         err_flag_q, err_flag_d;
   logic [MAX_RX_BYTES*8-1:0]    rx_buf_q, rx_buf_d;
   logic [MAX_RX_BYTES*8-1:0]    rx_data_q, rx_data_d;
   logic [7:0]                   mode;
   logic                         found;

   assign mode    = desc_q[95:88];
   assign gnt     = gnt_q;
   assign rx_data = rx_data_q;

   // State register and datapath flops, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         win_q      <= '0;
         gnt_q      <= '0;
         desc_q     <= '0;
         tx_q       <= '0;
         cnt_q      <= '0;
         poll_cnt_q <= '0;
         phase_q    <= 1'b0;
         err_flag_q <= 1'b0;
         rx_buf_q   <= '0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         win_q      <= win_d;
         gnt_q      <= gnt_d;
         desc_q     <= desc_d;
         tx_q       <= tx_d;
         cnt_q      <= cnt_d;
         poll_cnt_q <= poll_cnt_d;
         phase_q    <= phase_d;
         err_flag_q <= err_flag_d;
         rx_buf_q   <= rx_buf_d;
         rx_data_q  <= rx_data_d;
      end
   end

   // Next-state logic plus the master bus and done/err outputs.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      win_d      = win_q;
      gnt_d      = gnt_q;
      desc_d     = desc_q;
      tx_d       = tx_q;
      cnt_d      = cnt_q;
      poll_cnt_d = poll_cnt_q;
      phase_d    = phase_q;
      err_flag_d = err_flag_q;
      rx_buf_d   = rx_buf_q;
      rx_data_d  = rx_data_q;
      spi_addr   = '0;
      spi_wdata  = '0;
      spi_we     = 1'b0;
      done       = '0;
      err        = 1'b0;
      found      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (|req) begin
               // Outer loop is the distance from rr_ptr, so the first hit is
               // the nearest requester upward (wrapping).
               for (int unsigned i = 0; i < NUM_REQ; i++) begin
                  for (int unsigned j = 0; j < NUM_REQ; j++) begin
                     if (!found && rr_ptr_q == IW'(j) && req[(i + j) % NUM_REQ]) begin
                        found = 1'b1;
                        win_d = IW'((i + j) % NUM_REQ);
                     end
                  end
               end
               gnt_d        = '0;
               gnt_d[win_d] = 1'b1;
               state_d      = S_ARB;
            end
         end

         S_ARB: begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               if (win_q == IW'(i)) begin
                  desc_d = req_desc[96*i +: 96];
                  tx_d   = req_tx_data[MAX_TX_BYTES*8*i +: MAX_TX_BYTES*8];
               end
            end
            rr_ptr_d = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
            cnt_d    = '0;
            state_d  = S_LOAD;
         end

         S_LOAD: begin
            spi_we   = 1'b1;
            spi_addr = 8'(cnt_q) + 8'd1;
            for (int unsigned k = 0; k < 11; k++) begin
               if (cnt_q == 6'(k)) spi_wdata = desc_q[8*(10-k) +: 8];
            end
            for (int unsigned k = 0; k < MAX_TX_BYTES; k++) begin
               if (cnt_q == 6'(11 + k)) spi_wdata = tx_q[8*k +: 8];
            end
            if (cnt_q == 6'(LOAD_LAST)) begin
               cnt_d   = '0;
               state_d = S_KICK;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end

         S_KICK: begin
            spi_we     = 1'b1;
            spi_wdata  = mode | 8'h04;
            poll_cnt_d = '0;
            phase_d    = 1'b0;
            state_d    = S_POLL;
         end

         S_POLL: begin
            // Phase 0 presents address 0; phase 1 sees the registered data.
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (!spi_rdata[2]) begin
                  cnt_d   = '0;
                  state_d = S_READ;
               end else if (poll_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                  state_d = S_ABORT;
               end else begin
                  poll_cnt_d = poll_cnt_q + 1'b1;
               end
            end
         end

         S_READ: begin
            spi_addr = 8'd30 + 8'(cnt_q);
            for (int unsigned k = 0; k < MAX_RX_BYTES; k++) begin
               if (cnt_q == 6'(k + 1)) rx_buf_d[8*k +: 8] = spi_rdata;
            end
            // rx_data only moves on the last read cycle so it stays stable
            // from one done to the next.
            if (cnt_q == 6'(MAX_RX_BYTES)) begin
               rx_data_d = rx_buf_d;
               state_d   = S_DONE;
            end else begin
               cnt_d = cnt_q + 6'd1;
            end
         end

         S_ABORT: begin
            spi_we     = 1'b1;
            spi_wdata  = mode & 8'hFB;
            err_flag_d = 1'b1;
            state_d    = S_DONE;
         end

         S_DONE: begin
            done       = gnt_q;
            err        = err_flag_q;
            gnt_d      = '0;
            err_flag_d = 1'b0;
            state_d    = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Bench for quick_spi_arbiter: a register-map model of the quick_spi master,
// randomized descriptors, and a transaction-level reference model.
module tb_quick_spi_arbiter;

   localparam int NR  = 4;
   localparam int TXB = 4;
   localparam int RXB = 4;
   localparam int TO  = 40;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic [NR-1:0]         req = '0;
   logic [NR*96-1:0]      req_desc = '0;
   logic [NR*TXB*8-1:0]   req_tx_data = '0;
   logic [NR-1:0]         gnt, done;
   logic                  err;
   logic [RXB*8-1:0]      rx_data;
   logic [7:0]            spi_addr, spi_wdata, spi_rdata;
   logic                  spi_we;

   int errors = 0;
   int checks = 0;

   quick_spi_arbiter #(
      .NUM_REQ(NR), .MAX_TX_BYTES(TXB), .MAX_RX_BYTES(RXB), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_desc(req_desc),
      .req_tx_data(req_tx_data), .gnt(gnt), .done(done), .err(err),
      .rx_data(rx_data), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
      .spi_we(spi_we), .spi_rdata(spi_rdata)
   );

   always #5 clk = ~clk;

   // Descriptor fields per requester
   logic [7:0]  f_mode [NR];
   logic [7:0]  f_slave[NR];
   logic [15:0] f_txes [NR];
   logic [15:0] f_ntx  [NR];
   logic [15:0] f_rxes [NR];
   logic [15:0] f_wrx  [NR];
   logic [15:0] f_rdx  [NR];
   logic [7:0]  f_tx   [NR][TXB];

   // quick_spi master model: register file, registered read, start bit
   // cleared clear_delay cycles after a kick (0 = at once, negative = never).
   logic [7:0]  regs [256];
   logic [7:0]  rb [4];
   logic [15:0] wlog [$];
   int          clear_delay = 1;
   int          cd = -1;

   always @(posedge clk) begin
      if (spi_addr >= 8'd30 && spi_addr < 8'd34) spi_rdata <= rb[2'(spi_addr - 8'd30)];
      else                                       spi_rdata <= regs[spi_addr];
      if (spi_we) begin
         wlog.push_back({spi_addr, spi_wdata});
         if (spi_addr == 8'd0 && spi_wdata[2] && clear_delay == 0) regs[0] <= spi_wdata & 8'hFB;
         else                                                       regs[spi_addr] <= spi_wdata;
         cd <= (spi_addr == 8'd0 && spi_wdata[2] && clear_delay > 0) ? clear_delay : -1;
      end else if (cd > 0) begin
         if (cd == 1) regs[0] <= regs[0] & 8'hFB;
         cd <= cd - 1;
      end
   end

   int         rr = 0;
   logic [31:0] last_rx = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic randomize_all();
      for (int r = 0; r < NR; r++) begin
         f_mode[r]  = 8'($urandom);
         f_slave[r] = 8'($urandom);
         f_txes[r]  = 16'($urandom);
         f_ntx[r]   = 16'($urandom);
         f_rxes[r]  = 16'($urandom);
         f_wrx[r]   = 16'($urandom);
         f_rdx[r]   = 16'($urandom);
         for (int k = 0; k < TXB; k++) f_tx[r][k] = 8'($urandom);
      end
      for (int k = 0; k < 4; k++) rb[k] = 8'($urandom);
   endtask

   task automatic drive_inputs();
      for (int r = 0; r < NR; r++) begin
         req_desc[96*r +: 96] = {f_mode[r], f_slave[r], f_txes[r], f_ntx[r],
                                 f_rxes[r], f_wrx[r], f_rdx[r]};
         for (int k = 0; k < TXB; k++) req_tx_data[(r*TXB + k)*8 +: 8] = f_tx[r][k];
      end
   endtask

   // One transaction: reference winner/bus writes/result, then watch the DUT.
   task automatic do_txn(input logic [NR-1:0] r, input int delay,
                         input logic [NR-1:0] late, input bit use_late);
      int            win, cyc, gcyc;
      bit            to, seen;
      logic [NR-1:0] gnt_seen, exp_oh;
      logic [7:0]    cfg [11];
      logic [15:0]   exp_w [$];
      logic [31:0]   exp_rx;

      win = -1;
      for (int i = 0; i < NR; i++) begin
         if (win < 0 && r[(rr + i) % NR]) win = (rr + i) % NR;
      end
      exp_oh = '0;
      exp_oh[win] = 1'b1;
      to = (delay < 0);
      cfg = '{f_slave[win], f_txes[win][15:8], f_txes[win][7:0], f_ntx[win][15:8],
              f_ntx[win][7:0], f_rxes[win][15:8], f_rxes[win][7:0], f_wrx[win][15:8],
              f_wrx[win][7:0], f_rdx[win][15:8], f_rdx[win][7:0]};
      for (int a = 0; a < 11; a++) exp_w.push_back({8'(a + 1), cfg[a]});
      for (int k = 0; k < TXB; k++) exp_w.push_back({8'(12 + k), f_tx[win][k]});
      exp_w.push_back({8'h00, f_mode[win] | 8'h04});
      if (to) exp_w.push_back({8'h00, f_mode[win] & 8'hFB});
      exp_rx = to ? last_rx : {rb[3], rb[2], rb[1], rb[0]};

      drive_inputs();
      clear_delay = delay;
      wlog.delete();
      req = r;
      cyc = 0; gcyc = 0; seen = 0; gnt_seen = '0;
      while (cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (seen && cyc == gcyc + 1) begin
            // descriptor already latched; later changes must be ignored
            req_desc    = {12{$urandom}};
            req_tx_data = {4{$urandom}};
         end
         if (!seen && gnt != '0) begin
            seen = 1; gcyc = cyc; gnt_seen = gnt;
            if (use_late) req = late;
         end
         if (done != '0) break;
      end
      chk("done_seen", done != '0, 1);
      chk("gnt_at_grant", gnt_seen, exp_oh);
      chk("gnt_held", gnt, exp_oh);
      chk("done", done, exp_oh);
      chk("err", err, to);
      chk("rx_data", rx_data, exp_rx);
      if (delay == 0) chk("min_latency", cyc, 25);
      if (to) chk("timeout_latency", cyc, 2*TO + 19);
      chk("write_count", wlog.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < wlog.size(); i++)
         chk($sformatf("write[%0d]", i), wlog[i], exp_w[i]);
      last_rx = exp_rx;
      rr = (win + 1) % NR;
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("gnt_clear", gnt, 0);
      chk("err_clear", err, 0);
   endtask

   initial begin
      int wcyc, pulses;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rx", rx_data, 0);
      chk("rst_we", spi_we, 0);
      chk("rst_addr", spi_addr, 0);
      chk("rst_wdata", spi_wdata, 0);
      reset_n = 1'b1;

      // single request with fixed descriptor and readback pattern
      randomize_all();
      f_slave[0] = 8'h01; f_txes[0] = 16'd8; f_ntx[0] = 16'd2;
      f_tx[0][0] = 8'h1A; f_tx[0][1] = 8'h6A;
      rb[0] = 8'hA5; rb[1] = 8'h5A; rb[2] = 8'h3C; rb[3] = 8'hC3;
      do_txn(4'b0001, 50, '0, 0);
      chk("readback_const", rx_data, 32'hC33C5AA5);

      // immediate completion: minimum latency
      randomize_all();
      do_txn(4'b0010, 0, '0, 0);

      // round-robin with all requests held
      for (int t = 0; t < 5; t++) begin
         randomize_all();
         do_txn(4'b1111, int'($urandom_range(1, 20)), '0, 0);
      end

      // requester 0 drops, requester 2 arrives while 0 is busy
      randomize_all();
      do_txn(4'b0001, 10, 4'b0100, 1);
      randomize_all();
      do_txn(4'b0100, 5, '0, 0);

      // timeout: start bit never clears
      randomize_all();
      do_txn(4'b1000, -1, '0, 0);

      // reset mid-LOAD
      randomize_all();
      drive_inputs();
      clear_delay = 5;
      req = 4'b0001;
      wcyc = 0;
      while (wcyc < 50 && !spi_we) begin
         @(negedge clk);
         wcyc++;
      end
      chk("load_seen", spi_we, 1);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      req = '0;
      @(negedge clk);
      chk("mid_rst_gnt", gnt, 0);
      chk("mid_rst_we", spi_we, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_rx", rx_data, 0);
      reset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done != '0) pulses++;
      end
      chk("no_done_after_rst", pulses, 0);
      rr = 0;
      last_rx = '0;
      randomize_all();
      do_txn(4'b0011, 3, '0, 0);

      // randomized traffic
      for (int t = 0; t < 6; t++) begin
         logic [NR-1:0] rq;
         rq = NR'($urandom_range(1, 15));
         randomize_all();
         do_txn(rq, int'($urandom_range(0, 30)), '0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
